// File: rtl/booth_arb_pkg.sv
// Shared definitions for the Booth multiplier arbiter: state encoding and
// operand/product widths.
package booth_arb_pkg;

    localparam logic [1:0] IDLE   = 2'd0;
    localparam logic [1:0] LAUNCH = 2'd1;
    localparam logic [1:0] WAIT   = 2'd2;
    localparam logic [1:0] DONE   = 2'd3;

    localparam int OP_W   = 8;
    localparam int PROD_W = 16;

    typedef enum logic [1:0] {
        ST_IDLE   = IDLE,
        ST_LAUNCH = LAUNCH,
        ST_WAIT   = WAIT,
        ST_DONE   = DONE
    } state_t;

endpackage

// File: rtl/booth_mult_arbiter_booth.sv
// Sequential radix-2 Booth multiplier: one recoding step per cycle,
// valid pulses OP_W+1 cycles after start; a new start always restarts it.
module Booth_Multiplier
    import booth_arb_pkg::*;
(
    input  logic                     clock,
    input  logic                     reset,
    input  logic                     start,
    input  logic signed [OP_W-1:0]   X,
    input  logic signed [OP_W-1:0]   Y,
    output logic                     valid,
    output logic signed [PROD_W-1:0] Z
);

    // two guard bits keep the partial sum from overflowing on -128 operands
    logic signed [OP_W+1:0] acc_hi;
    logic signed [OP_W+1:0] m_ext;
    logic signed [OP_W+1:0] sum;
    logic signed [OP_W+1:0] nxt_hi;
    logic        [OP_W-1:0] acc_lo;
    logic        [OP_W-1:0] nxt_lo;
    logic                   acc_q;
    logic        [3:0]      cnt;

    always_comb begin
        sum = acc_hi;
        case ({acc_lo[0], acc_q})
            2'b01:   sum = acc_hi + m_ext;
            2'b10:   sum = acc_hi - m_ext;
            default: sum = acc_hi;
        endcase
        nxt_hi = sum >>> 1;
        nxt_lo = {sum[0], acc_lo[OP_W-1:1]};
    end

    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            cnt   <= '0;
            valid <= 1'b0;
        end else begin
            valid <= 1'b0;
            if (start) begin
                cnt <= 4'(OP_W);
            end else if (cnt != '0) begin
                cnt <= cnt - 1'b1;
                if (cnt == 4'd1) valid <= 1'b1;
            end
        end
    end

    always_ff @(posedge clock) begin
        if (start) begin
            acc_hi <= '0;
            acc_lo <= Y;
            acc_q  <= 1'b0;
            m_ext  <= {{2{X[OP_W-1]}}, X};
        end else if (cnt != '0) begin
            acc_hi <= nxt_hi;
            acc_lo <= nxt_lo;
            acc_q  <= acc_lo[0];
            if (cnt == 4'd1) Z <= {nxt_hi[OP_W-1:0], nxt_lo};
        end
    end

endmodule

// File: rtl/booth_mult_arbiter.sv
// Round-robin scheduler sharing one Booth_Multiplier among NUM_REQ clients;
// returns each product tagged with its requester ID, or an error on timeout.
module booth_mult_arbiter
    import booth_arb_pkg::*;
#(
    parameter int NUM_REQ = 4,
    parameter int ID_W    = 2,
    parameter int TIMEOUT = 31
) (
    input  logic                     clock,
    input  logic                     reset,
    input  logic [NUM_REQ-1:0]       req,
    input  logic [NUM_REQ*OP_W-1:0]  a_in,
    input  logic [NUM_REQ*OP_W-1:0]  b_in,
    output logic [NUM_REQ-1:0]       gnt,
    output logic                     rsp_valid,
    output logic [ID_W-1:0]          rsp_id,
    output logic signed [PROD_W-1:0] rsp_z,
    output logic                     rsp_err,
    output logic                     busy
);

    localparam int CNT_W = $clog2(TIMEOUT + 1);

    state_t                   state;
    logic [ID_W-1:0]          rr_ptr;
    logic [ID_W-1:0]          cur_id;
    logic [CNT_W-1:0]         wait_cnt;
    logic                     mul_start;
    logic                     mul_valid;
    logic signed [OP_W-1:0]   mul_x;
    logic signed [OP_W-1:0]   mul_y;
    logic signed [PROD_W-1:0] mul_z;
    logic                     pick_hit;
    logic [ID_W-1:0]          pick_id;

    // walk downward so the smallest offset from ptr is the one left standing
    function automatic logic [ID_W:0] rr_pick(input logic [NUM_REQ-1:0] r,
                                              input logic [ID_W-1:0]    ptr);
        logic [ID_W:0] res;
        int            idx;
        res = '0;
        for (int k = NUM_REQ - 1; k >= 0; k--) begin
            idx = int'(ptr) + k;
            if (idx >= NUM_REQ) idx = idx - NUM_REQ;
            if (r[idx]) res = {1'b1, idx[ID_W-1:0]};
        end
        return res;
    endfunction

    assign {pick_hit, pick_id} = rr_pick(req, rr_ptr);
    assign busy = (state != ST_IDLE);

    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            state     <= ST_IDLE;
            rr_ptr    <= '0;
            cur_id    <= '0;
            gnt       <= '0;
            mul_start <= 1'b0;
            wait_cnt  <= '0;
            rsp_valid <= 1'b0;
            rsp_id    <= '0;
            rsp_z     <= '0;
            rsp_err   <= 1'b0;
        end else begin
            rsp_valid <= 1'b0;
            case (state)
                ST_IDLE: begin
                    if (pick_hit) begin
                        cur_id    <= pick_id;
                        gnt       <= NUM_REQ'(1) << pick_id;
                        mul_start <= 1'b1;
                        state     <= ST_LAUNCH;
                    end
                end
                ST_LAUNCH: begin
                    gnt       <= '0;
                    mul_start <= 1'b0;
                    rr_ptr    <= (cur_id == ID_W'(NUM_REQ - 1)) ? '0 : cur_id + 1'b1;
                    wait_cnt  <= '0;
                    state     <= ST_WAIT;
                end
                ST_WAIT: begin
                    wait_cnt <= wait_cnt + 1'b1;
                    // wait_cnt==0 masks a valid left over from the previous operation
                    if (mul_valid && wait_cnt != '0) begin
                        rsp_z     <= mul_z;
                        rsp_err   <= 1'b0;
                        rsp_id    <= cur_id;
                        rsp_valid <= 1'b1;
                        state     <= ST_DONE;
                    end else if (wait_cnt == CNT_W'(TIMEOUT)) begin
                        rsp_z     <= '0;
                        rsp_err   <= 1'b1;
                        rsp_id    <= cur_id;
                        rsp_valid <= 1'b1;
                        state     <= ST_DONE;
                    end
                end
                ST_DONE: state <= ST_IDLE;
                default: state <= ST_IDLE;
            endcase
        end
    end

    always_ff @(posedge clock) begin
        if (state == ST_IDLE && pick_hit) begin
            mul_x <= a_in[pick_id*OP_W +: OP_W];
            mul_y <= b_in[pick_id*OP_W +: OP_W];
        end
    end

    Booth_Multiplier u_mul (
        .clock (clock),
        .reset (reset),
        .start (mul_start),
        .X     (mul_x),
        .Y     (mul_y),
        .valid (mul_valid),
        .Z     (mul_z)
    );

endmodule

// File: doc/booth_mult_arbiter.md
# booth_mult_arbiter

Round-robin scheduler that shares one 8-bit signed Booth_Multiplier among NUM_REQ requesters. It accepts operand pairs over a req/gnt handshake, launches the multiplier with a one-cycle start pulse, and waits for its valid. It returns the 16-bit product tagged with the requester ID. It sits between client blocks and the single multiplier instance, which it owns.

## Interface

Parameters:
- NUM_REQ, 4, number of requesters (2..8)
- ID_W, 2, width of rsp_id, equal to clog2(NUM_REQ)
- TIMEOUT, 31, maximum WAIT cycles before the operation is aborted with an error

Ports:
- clock  in  1  single clock, rising edge
- reset  in  1  asynchronous, active-low reset; also drives the multiplier's reset
- req  in  NUM_REQ  per-requester request level
- a_in  in  NUM_REQ*8  packed signed multiplicands; requester i uses bits [8i+7:8i]
- b_in  in  NUM_REQ*8  packed signed multipliers, same packing as a_in
- gnt  out  NUM_REQ  one-hot pulse, one cycle: operands of that requester were captured
- rsp_valid  out  1  one-cycle pulse: rsp_* fields are valid
- rsp_id  out  ID_W  index of the requester that owns the response
- rsp_z  out  16  signed product; 0 when rsp_err is 1
- rsp_err  out  1  timeout flag, qualified by rsp_valid
- busy  out  1  high in every state except IDLE

## Operation

- States: IDLE, LAUNCH, WAIT, DONE.
- IDLE:
  - When req != 0, pick the first asserted req at or after rr_ptr, searching upward with wrap.
  - Latch that requester's a/b into mul_x/mul_y and latch its ID.
  - Set gnt[ID] and go to LAUNCH.
- LAUNCH (one cycle):
  - gnt[ID]=1 and mul_start=1.
  - Set rr_ptr = ID+1 mod NUM_REQ; clear wait_cnt; go to WAIT.
- WAIT:
  - wait_cnt increments every cycle.
  - mul_valid is ignored while wait_cnt==0, which masks a stale valid left over from the previous operation.
  - When mul_valid=1 and wait_cnt>=1: capture mul_z and set err=0; go to DONE.
  - Otherwise, when wait_cnt==TIMEOUT: set z=0 and err=1; go to DONE.
  - If both conditions hold in the same cycle, valid wins.
- DONE (one cycle): rsp_valid=1 with rsp_id/rsp_z/rsp_err driven from registers; go to IDLE.
- Requester rules:
  - Hold req and operands stable until gnt is seen.
  - Deassert req in the cycle after gnt, or keep it asserted to queue another operation.
  - req is sampled only in IDLE.
- Arithmetic: operands are two's complement 8-bit and the product is 16-bit signed. The arbiter does no arithmetic of its own.
- Reset values:
  - State IDLE, rr_ptr=0.
  - gnt, rsp_valid, rsp_id, rsp_z, rsp_err, busy, mul_start all 0.
- Reset asserted mid-operation: everything returns to reset values immediately and asynchronously. The in-flight operation is dropped and produces no response.

## Timing

- All outputs are registered or decoded from state; there is no combinational path from req to any output.
- Cycle 0: req seen in IDLE.
- Cycle 1: gnt and mul_start high.
- Cycles 2 to 2+L: WAIT, where L is the multiplier latency.
- Cycle after mul_valid is captured: rsp_valid.
- Total response latency is L+3 cycles from the cycle req is seen.
- Minimum spacing between two grants is L+4 cycles.
- A timeout response comes TIMEOUT+3 cycles after req.

## Structure

- A shared package (booth_arb_pkg) holds:
  - the state encoding localparams IDLE=2'd0, LAUNCH=2'd1, WAIT=2'd2, DONE=2'd3;
  - OP_W=8 and PROD_W=16.
- One sub-module is natural: the existing Booth_Multiplier.
  - Ports in order: clock, reset, start, X, Y, valid, Z.
  - It is instantiated once inside this block.
- The round-robin search is a function or an always block inside this block, not a separate module.

## Test plan

- Single request: reset, req=4'b0001, a0=-56, b0=-70.
  - Expected: gnt=0001 on the next cycle, then one rsp_valid with rsp_id=0, rsp_z=3920, rsp_err=0.
- Extremes:
  - req2 with 127 × -128 → rsp_id=2, rsp_z=-16256.
  - req3 with -128 × -128 → rsp_z=16384.
- Round robin: req=4'b1111 held, each operand pair distinct.
  - Expected grant order 0,1,2,3,0, with each response's rsp_id matching its grant.
  - busy drops for exactly one cycle between operations.
- Pointer wrap: service req1, then assert req=4'b0011.
  - Expected: req0 is served after req1 only if no higher index is pending; requester 1 must not be granted twice in a row.
- Timeout: replace the multiplier with a stub whose valid is tied to 0.
  - Expected: rsp_valid occurs TIMEOUT+3 cycles after req, with rsp_err=1 and rsp_z=0; the next request is still served normally.
- Reset mid-operation: assert reset during WAIT.
  - Expected: outputs go to 0 without waiting for a clock edge, and no rsp_valid appears after release.
  - After release, req=4'b1000 is served first, because the pointer restarts at 0 and no lower-indexed requests are pending.
